clarke_park: RTL and testbench



---
 rtl/foc_pkg.sv | 13 +
 rtl/mul_s18x16.sv | 13 +
 rtl/clarke_park.sv | 102 ++++++++++
 tb/tb_clarke_park.sv | 125 ++++++++++++
 4 files changed

// File: rtl/foc_pkg.sv
// foc_pkg: constants, FSM encoding and saturation helper shared by the FOC datapath blocks
package foc_pkg;
    localparam int K_INV_SQRT3 = 18919;
    localparam int SHIFT = 15;
    typedef enum logic [2:0] {S_IDLE, S_BETA, S_D1, S_D2, S_Q1, S_Q2, S_OUT} cp_state_t;
    function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return x > hi ? hi : x < lo ? lo : x;
    endfunction
endpackage

// File: rtl/mul_s18x16.sv
// mul_s18x16: registered signed 18x16 multiplier, one product per cycle
module mul_s18x16 (
    input  logic               iClk,
    input  logic               iRst,
    input  logic signed [17:0] iA,
    input  logic signed [15:0] iB,
    output logic signed [33:0] oP
);
    always_ff @(posedge iClk) begin
        if (iRst) oP <= '0;
        else      oP <= 34'(iA) * 34'(iB);
    end
endmodule

// File: rtl/clarke_park.sv
// clarke_park: forward Clarke + Park transform (Ia/Ib, sin/cos -> Id/Iq)
// sequenced over one shared registered multiplier, 7 cycles per transform
module clarke_park #(
    parameter int DW = 12,
    parameter int TW = 16,
    parameter int K_INV_SQRT3 = foc_pkg::K_INV_SQRT3,
    parameter int SHIFT = foc_pkg::SHIFT
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iEn,
    input  logic signed [DW-1:0] iIa,
    input  logic signed [DW-1:0] iIb,
    input  logic signed [TW-1:0] iSin,
    input  logic signed [TW-1:0] iCos,
    output logic signed [DW-1:0] oId,
    output logic signed [DW-1:0] oIq,
    output logic                 oBusy,
    output logic                 oDone
);
    import foc_pkg::*;
    cp_state_t             r_st;
    logic signed [DW-1:0]  r_ia, r_ib;
    logic signed [TW-1:0]  r_sin, r_cos;
    logic signed [DW+1:0]  r_beta;
    logic signed [31:0]    r_acc_d, r_acc_q;
    logic signed [DW+1:0]  w_sum;
    logic signed [17:0]    w_a;
    logic signed [15:0]    w_b;
    logic signed [33:0]    w_p;
    logic signed [31:0]    w_p32, w_q;
    // operands are issued one state ahead of the state that consumes the product
    always_comb begin
        w_sum = (DW+2)'(r_ia) + ((DW+2)'(r_ib) <<< 1);
        w_a   = r_st == S_BETA ? 18'(w_sum) : (r_st == S_D2 || r_st == S_Q1) ? 18'(r_beta) : 18'(r_ia);
        w_b   = r_st == S_BETA ? 16'(K_INV_SQRT3) : (r_st == S_D1 || r_st == S_Q1) ? 16'(r_cos) : 16'(r_sin);
        w_p32 = 32'(w_p);
        w_q   = r_acc_q - w_p32;
    end
    mul_s18x16 u_mul (
        .iClk(iClk),
        .iRst(iRst),
        .iA  (w_a),
        .iB  (w_b),
        .oP  (w_p)
    );
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_st    <= S_IDLE;
            r_ia    <= '0;
            r_ib    <= '0;
            r_sin   <= '0;
            r_cos   <= '0;
            r_beta  <= '0;
            r_acc_d <= '0;
            r_acc_q <= '0;
            oId     <= '0;
            oIq     <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (r_st)
                S_IDLE: begin
                    oBusy <= iEn;
                    if (iEn) begin
                        r_ia  <= iIa;
                        r_ib  <= iIb;
                        r_sin <= iSin;
                        r_cos <= iCos;
                        r_st  <= S_BETA;
                    end
                end
                S_BETA: r_st <= S_D1;
                S_D1: begin
                    r_beta <= (DW+2)'(w_p >>> SHIFT);
                    r_st   <= S_D2;
                end
                S_D2: begin
                    r_acc_d <= w_p32;
                    r_st    <= S_Q1;
                end
                S_Q1: begin
                    r_acc_d <= r_acc_d + w_p32;
                    r_st    <= S_Q2;
                end
                S_Q2: begin
                    r_acc_q <= w_p32;
                    r_st    <= S_OUT;
                end
                S_OUT: begin
                    r_acc_q <= w_q;
                    oId     <= DW'(sat(r_acc_d >>> SHIFT, DW));
                    oIq     <= DW'(sat(w_q >>> SHIFT, DW));
                    oDone   <= 1'b1;
                    r_st    <= S_IDLE;
                end
                default: r_st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clarke_park.sv
// tb_clarke_park: randomized scoreboard bench for clarke_park against a plain-arithmetic model
module tb_clarke_park;
    logic iClk = 0, iRst = 1, iEn = 0;
    logic signed [11:0] iIa = 0, iIb = 0, oId, oIq;
    logic signed [15:0] iSin = 0, iCos = 0;
    logic oBusy, oDone;

    clarke_park dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iIa(iIa), .iIb(iIb),
        .iSin(iSin), .iCos(iCos), .oId(oId), .oIq(oIq), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClk = ~iClk;
    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct {int id; int iq; int due;} exp_t;
    exp_t q[$];
    int n_chk = 0, n_pass = 0;
    int busy_from = -10, busy_until = -10, prev_until = -10, next_ok = 0;

    typedef struct {int ia; int ib; int s; int c; int id; int iq;} vec_t;
    vec_t vecs[5] = '{
        '{1000, -500, 0, 32767, 999, 0},
        '{1000, 0, 32767, 0, 576, -1000},
        '{2047, 2047, 23170, 23170, 2047, 1059},
        '{2047, 0, 0, -32768, -2047, -1181},
        '{-2048, 0, 0, -32768, 2047, 1183}
    };

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    endtask

    function automatic int sat(input longint x);
        return x > 2047 ? 2047 : x < -2048 ? -2048 : int'(x);
    endfunction

    function automatic void model(input int ia, ib, s, c, output int id, iq);
        longint beta;
        beta = ((longint'(ia) + 2 * longint'(ib)) * 18919) >>> 15;
        id = sat((longint'(ia) * c + beta * s) >>> 15);
        iq = sat((beta * c - longint'(ia) * s) >>> 15);
    endfunction

    // e is the index of the edge that will sample the values driven here
    task automatic drive(input bit en, input bit rst, input int ia, ib, s, c,
                         input bit use_exp = 0, input int xid = 0, input int xiq = 0);
        int e, id, iq;
        e = cyc + 1;
        iEn = en; iRst = rst;
        iIa = 12'(ia); iIb = 12'(ib); iSin = 16'(s); iCos = 16'(c);
        if (rst) begin
            while (q.size() > 0 && q[$].due >= e) void'(q.pop_back());
            if (busy_until > e - 1) busy_until = e - 1;
            if (prev_until > e - 1) prev_until = e - 1;
            next_ok = e + 1;
        end else if (en && e >= next_ok) begin
            model(ia, ib, s, c, id, iq);
            if (use_exp) begin id = xid; iq = xiq; end
            q.push_back('{id, iq, e + 6});
            prev_until = busy_until;
            busy_from = e;
            busy_until = e + 6;
            next_ok = e + 7;
        end
        @(posedge iClk);
        #1;
    endtask

    initial forever begin
        exp_t x;
        @(negedge iClk);
        chk("busy", int'(oBusy), int'((cyc >= busy_from && cyc <= busy_until) || cyc <= prev_until));
        if (oDone) begin
            if (q.size() == 0) chk("spurious_done", 1, 0);
            else begin
                x = q.pop_front();
                chk("id", int'(oId), x.id);
                chk("iq", int'(oIq), x.iq);
                chk("done_cycle", cyc, x.due);
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            chk("missing_done", 0, 1);
            void'(q.pop_front());
        end
    end

    initial begin
        int ia, ib, s, c;
        repeat (3) drive(0, 1, 0, 0, 0, 0);
        chk("rst_id", int'(oId), 0);
        chk("rst_iq", int'(oIq), 0);
        chk("rst_done", int'(oDone), 0);
        foreach (vecs[i]) begin
            drive(1, 0, vecs[i].ia, vecs[i].ib, vecs[i].s, vecs[i].c, 1, vecs[i].id, vecs[i].iq);
            repeat (8) drive(0, 0, 0, 0, 0, 0);
        end
        repeat (30) drive(1, 0, 300, -700, 12000, -20000);
        repeat (8) drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 500, 300, 10000, 20000);
        drive(0, 0, 1, 1, 1, 1);
        drive(0, 0, 2, 2, 2, 2);
        drive(1, 1, 3, 3, 3, 3);
        chk("abort_id", int'(oId), 0);
        chk("abort_iq", int'(oIq), 0);
        chk("abort_busy", int'(oBusy), 0);
        chk("abort_done", int'(oDone), 0);
        drive(1, 0, -1500, 900, -30000, 5000);
        repeat (8) drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            ia = int'($urandom_range(0, 4095)) - 2048;
            ib = int'($urandom_range(0, 4095)) - 2048;
            s  = int'($urandom_range(0, 65535)) - 32768;
            c  = int'($urandom_range(0, 65535)) - 32768;
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0, ia, ib, s, c);
        end
        for (int i = 0; i < 20 && q.size() > 0; i++) drive(0, 0, 0, 0, 0, 0);
        chk("drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
